// File: rtl/latch_bank_loader_if.sv
// -----------------------------------------------------------------------------
// latch_bank_loader_if
// Bundles the producer handshake and the latch-bank drive signals of
// latch_bank_loader.
//   dav_      producer -> loader   data valid, active low
//   data      producer -> loader   word to load, valid while dav_ = 0
//   rfd       loader -> producer   ready for data, active high
//   d         loader -> bank       shared latch data bus
//   c         loader -> bank       shared latch enable (transparent when 1)
//   preclear_ loader -> bank       shared latch clear, active low
//   q_mirror  loader -> observer   copy of the last word strobed into the bank
//   count     loader -> observer   completed loads, modulo 256
// Modports: master = producer/observer side, slave = the loader itself.
// -----------------------------------------------------------------------------
interface latch_bank_loader_if #(
  parameter int W = 8
);
  logic         dav_;
  logic [W-1:0] data;
  logic         rfd;
  logic [W-1:0] d;
  logic         c;
  logic         preclear_;
  logic [W-1:0] q_mirror;
  logic [7:0]   count;

  modport master (
    output dav_, data,
    input  rfd, d, c, preclear_, q_mirror, count
  );

  modport slave (
    input  dav_, data,
    output rfd, d, c, preclear_, q_mirror, count
  );
endinterface

// File: rtl/latch_bank_loader.sv
// -----------------------------------------------------------------------------
// latch_bank_loader
// Accepts one word per dav_ low pulse from a producer and loads it into a
// W-bit bank of D latches with a setup / strobe / hold sequence on the shared
// bus d and enable c. Keeps a mirror of the last loaded word and a load count.
// Ports:
//   clock   single clock, all state changes on the rising edge
//   reset_  asynchronous active-low reset
//   bus     latch_bank_loader_if.slave (handshake, latch drive, observability)
// Every output comes straight from a flop so the latch enable and clear never
// glitch and there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module latch_bank_loader #(
  parameter int W          = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                  clock,
  input  logic                  reset_,
  latch_bank_loader_if.slave    bus
);

  // Phase counter runs 0 .. N-1 inside SETUP and STROBE.
  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          rfd_q, rfd_d;
  logic          c_q, c_d;
  logic          pre_q, pre_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  mirror_q, mirror_d;
  logic [7:0]    count_q, count_d;

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= S_INIT;
      cyc_q    <= '0;
      rfd_q    <= 1'b0;
      c_q      <= 1'b0;
      pre_q    <= 1'b0;
      d_q      <= '0;
      mirror_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      rfd_q    <= rfd_d;
      c_q      <= c_d;
      pre_q    <= pre_d;
      d_q      <= d_d;
      mirror_q <= mirror_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_INIT:    state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.dav_) begin
          state_d = S_SETUP;
          cyc_d   = '0;
        end
      end
      S_SETUP: begin
        if (cyc_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cyc_q == STROBE_LAST) begin
          state_d = S_HOLD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      // A producer still holding dav_ low after the strobe has not finished
      // its pulse yet; RELEASE stops that pulse from being taken twice.
      S_HOLD:    state_d = bus.dav_ ? S_WAIT : S_RELEASE;
      S_RELEASE: if (bus.dav_) state_d = S_WAIT;
      default:   state_d = S_INIT;
    endcase
  end

  // Output next values, driven by the transition being taken this edge.
  always_comb begin
    rfd_d    = rfd_q;
    c_d      = c_q;
    pre_d    = pre_q;
    d_d      = d_q;
    mirror_d = mirror_q;
    count_d  = count_q;
    unique case (state_q)
      S_INIT: begin
        pre_d = 1'b1;
        rfd_d = 1'b1;
      end
      S_WAIT: begin
        // data is sampled only here; d stays frozen until the next capture.
        if (state_d == S_SETUP) begin
          d_d   = bus.data;
          rfd_d = 1'b0;
        end
      end
      S_SETUP: if (state_d == S_STROBE) c_d = 1'b1;
      S_STROBE: begin
        if (state_d == S_HOLD) begin
          c_d      = 1'b0;
          mirror_d = d_q;
          count_d  = count_q + 8'd1;
        end
      end
      S_HOLD, S_RELEASE: if (state_d == S_WAIT) rfd_d = 1'b1;
      default: begin
        rfd_d = 1'b0;
        c_d   = 1'b0;
      end
    endcase
  end

  assign bus.rfd       = rfd_q;
  assign bus.c         = c_q;
  assign bus.preclear_ = pre_q;
  assign bus.d         = d_q;
  assign bus.q_mirror  = mirror_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_latch_bank_loader.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_loader
// Drives latch_bank_loader through reset, directed and randomized loads and a
// reset in the middle of a strobe. Expected values come from a transaction
// model: the last word loaded, the number of loads, and the fixed timing
// offsets measured from each capture edge.
// -----------------------------------------------------------------------------
module tb_latch_bank_loader;

  localparam int W          = 8;
  localparam int SETUP_CYC  = 1;
  localparam int STROBE_CYC = 2;

  logic clock;
  logic reset_;

  latch_bank_loader_if #(.W(W)) bus ();

  latch_bank_loader #(
    .W         (W),
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC)
  ) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: last fully loaded word and number of loads.
  logic [W-1:0] model_word;
  int           model_loads;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Asserts reset away from any edge, checks the cleared outputs, releases
  // reset and checks the first edge afterwards.
  task automatic do_reset();
    #1;
    reset_ = 1'b0;
    #1;
    check("rst_preclear", 32'(bus.preclear_), 32'd0);
    check("rst_rfd",      32'(bus.rfd),       32'd0);
    check("rst_c",        32'(bus.c),         32'd0);
    check("rst_d",        32'(bus.d),         32'd0);
    check("rst_mirror",   32'(bus.q_mirror),  32'd0);
    check("rst_count",    32'(bus.count),     32'd0);
    model_word  = '0;
    model_loads = 0;
    @(negedge clock);
    bus.dav_ = 1'b1;
    reset_   = 1'b1;
    #1;
    check("rel_preclear_low", 32'(bus.preclear_), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("rel_preclear_high", 32'(bus.preclear_), 32'd1);
    check("rel_rfd_high",      32'(bus.rfd),       32'd1);
  endtask

  // One complete load: called at a negedge with rfd expected high. dav_ is
  // sampled low by `low_edges` consecutive edges starting at the capture edge.
  // When `chg` is set, data is switched to `late` right after the capture.
  task automatic load(input logic [W-1:0] w, input int low_edges,
                      input bit chg, input logic [W-1:0] late);
    int rise;
    int done;
    done = SETUP_CYC + STROBE_CYC;
    rise = (done + 1 > low_edges) ? done + 1 : low_edges;
    check("ready", 32'(bus.rfd), 32'd1);
    bus.data = w;
    bus.dav_ = 1'b0;
    for (int t = 0; t <= rise; t++) begin
      @(posedge clock);
      @(negedge clock);
      if (t + 1 == low_edges) bus.dav_ = 1'b1;
      if (chg) bus.data = late;
      check("c",         32'(bus.c),         32'(t >= SETUP_CYC && t < done));
      check("d",         32'(bus.d),         32'(w));
      check("rfd",       32'(bus.rfd),       32'(t >= rise));
      check("preclear_", 32'(bus.preclear_), 32'd1);
      check("mirror",    32'(bus.q_mirror),  32'(t >= done ? w : model_word));
      check("count",     32'(bus.count),     32'((t >= done ? model_loads + 1 : model_loads) % 256));
    end
    model_word  = w;
    model_loads = model_loads + 1;
  endtask

  initial begin
    reset_   = 1'b0;
    bus.dav_ = 1'b1;
    bus.data = '0;
    model_word  = '0;
    model_loads = 0;

    // Reset and first edge after release.
    do_reset();

    // Single load of A5 with dav_ low for two edges.
    load(8'hA5, 2, 1'b0, 8'h00);

    // Slow producer: dav_ low for 20 cycles gives exactly one load.
    load(8'($urandom), 20, 1'b0, 8'h00);

    // Data switched to FF during SETUP must not disturb the captured 3C.
    load(8'h3C, 2, 1'b1, 8'hFF);
    check("mirror_3c", 32'(bus.q_mirror), 32'h3C);

    // Randomized words, pulse lengths and late data changes.
    for (int i = 0; i < 24; i++) begin
      load(8'($urandom), int'($urandom_range(1, 9)), 1'($urandom), 8'($urandom));
    end

    // Reset while the strobe is active: the partial load is dropped.
    bus.data = 8'h5A;
    bus.dav_ = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.dav_ = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_c_high", 32'(bus.c), 32'd1);
    do_reset();
    load(8'h77, 1, 1'b0, 8'h00);

    // Reset again, then 256 back-to-back loads at the minimum period.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      load(8'(i), 1, 1'b0, 8'h00);
    end
    check("wrap_count",  32'(bus.count),    32'd0);
    check("wrap_mirror", 32'(bus.q_mirror), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
